// File: rtl/btn_frontend_pkg.sv
// rtl/btn_frontend_pkg.sv - shared constants and width helpers for the button event front end
package btn_frontend_pkg;

  localparam int BTN_RIGHT    = 0;
  localparam int BTN_LEFT     = 1;
  localparam int BTN_DOWN     = 2;
  localparam int BTN_UP       = 3;
  localparam int BTN_DECISION = 4;
  localparam int BTN_RED_RST  = 5;
  localparam int BTN_BLUE_RST = 6;

  localparam int DEB_CNT_W = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int code_width(input int num_btn);
    return (clog2(num_btn) < 1) ? 1 : clog2(num_btn);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one button channel: synchroniser, tick debouncer, press pulse
// Auto-repeat counter is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce
  import btn_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 3,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE  = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam logic [DEB_CNT_W-1:0] DEB_TARGET = DEB_CNT_W'(DEBOUNCE_CNT);

  logic                 sync1_q, sync2_q;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 level_dly_q;
  logic                 press_q, press_d;
  logic                 rep_fire;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (tick_i) begin
      if (sync2_q != level_q) begin
        if (cnt_q + DEB_CNT_W'(1) == DEB_TARGET) begin
          cnt_d   = '0;
          level_d = ~level_q;
        end else begin
          cnt_d = cnt_q + DEB_CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign press_d = (level_q & ~level_dly_q) | rep_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= raw_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RCNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCNT_W   = (clog2(RCNT_MAX + 1) < 1) ? 1 : clog2(RCNT_MAX + 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              armed_q, armed_d;

  // armed_q separates the long initial hold delay from the shorter repeat period
  always_comb begin
    rcnt_d   = rcnt_q;
    armed_d  = armed_q;
    rep_fire = 1'b0;
    if (!level_q) begin
      rcnt_d  = '0;
      armed_d = 1'b0;
    end else if (tick_i) begin
      if (rcnt_q == (armed_q ? RATE_LAST : DELAY_LAST)) begin
        rep_fire = 1'b1;
        rcnt_d   = '0;
        armed_d  = 1'b1;
      end else begin
        rcnt_d = rcnt_q + RCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rcnt_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      rcnt_q  <= rcnt_d;
      armed_q <= armed_d;
    end
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
  assign rep_fire = 1'b0;
`endif

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/btn_event_frontend.sv
// rtl/btn_event_frontend.sv - debounced buttons feeding a priority arbiter and event FIFO
// Optional auto-repeat of held buttons is enabled with BTN_AUTO_REPEAT_EN.
module btn_event_frontend
  import btn_frontend_pkg::*;
#(
  parameter int NUM_BTN      = 7,
  parameter int TICK_DIV     = 2_000_000,
  parameter int DEBOUNCE_CNT = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE  = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_BTN-1:0]                btn_raw,
  output logic [NUM_BTN-1:0]                btn_level,
  output logic [NUM_BTN-1:0]                btn_press,
  output logic                              evt_valid,
  output logic [code_width(NUM_BTN)-1:0]    evt_code,
  input  logic                              evt_ready,
  output logic [clog2(FIFO_DEPTH):0]        evt_count,
  output logic                              overflow
);

  localparam int CODE_W = code_width(NUM_BTN);
  localparam int PTR_W  = clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int TICK_W = clog2(TICK_DIV);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  assign tick       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

  always_ff @(posedge clk) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    btn_debounce #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .tick_i (tick),
      .raw_i  (btn_raw[g]),
      .level_o(btn_level[g]),
      .press_o(btn_press[g])
    );
  end

  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] sel_mask;
  logic               sel_valid;
  logic [CODE_W-1:0]  sel_code;

  // Later iterations overwrite earlier ones, so the highest pending index wins
  always_comb begin
    sel_valid = 1'b0;
    sel_code  = '0;
    sel_mask  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (pending_q[i]) begin
        sel_valid   = 1'b1;
        sel_code    = CODE_W'(i);
        sel_mask    = '0;
        sel_mask[i] = 1'b1;
      end
    end
  end

  assign pending_d = (pending_q & ~sel_mask) | btn_press;

  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              full, pop, push;

  assign full = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop  = (count_q != '0) && evt_ready;
  // A pop frees the slot in the same cycle, so a full queue can still accept
  assign push = sel_valid && (!full || pop);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    overflow_d = overflow_q | (sel_valid && !push);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pending_q  <= pending_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) mem_q[wr_ptr_q] <= sel_code;
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_code  = mem_q[rd_ptr_q];
  assign evt_count = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_btn_event_frontend.sv
// tb/tb_btn_event_frontend.sv - self-checking bench for btn_event_frontend
module tb_btn_event_frontend;

  localparam int NB = 7;
  localparam int TD = 4;
  localparam int DC = 3;
  localparam int FD = 4;
  localparam int RD = 5;
  localparam int RR = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_press;
  logic          evt_valid;
  logic [2:0]    evt_code;
  logic          evt_ready;
  logic [2:0]    evt_count;
  logic          overflow;

  always #5 clk = ~clk;

  btn_event_frontend #(
    .NUM_BTN(NB), .TICK_DIV(TD), .DEBOUNCE_CNT(DC),
    .FIFO_DEPTH(FD), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .evt_count(evt_count), .overflow(overflow)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw delayed two cycles, tick every TD cycles,
  // debounce by consecutive differing ticks, presses into a pending set,
  // highest pending index into a bounded queue.
  bit [NB-1:0] m_syn1, m_syn2, m_lvl, m_lvl_prev, m_press, m_pend;
  int          m_dcnt [NB];
  int          m_rt   [NB];
  int          m_q    [$];
  bit          m_ovf;
  int          m_cyc;
  bit          started = 1'b0;

  always @(posedge clk) begin : model
    bit [NB-1:0] n_lvl, n_press, sel;
    bit tick;
    int hi;
    if (reset) begin
      m_syn1 = '0; m_syn2 = '0; m_lvl = '0; m_lvl_prev = '0;
      m_press = '0; m_pend = '0; m_ovf = 1'b0; m_cyc = 0;
      for (int i = 0; i < NB; i++) begin m_dcnt[i] = 0; m_rt[i] = 0; end
      m_q.delete();
      started = 1'b1;
    end else begin
      tick    = (m_cyc % TD) == TD - 1;
      n_lvl   = m_lvl;
      n_press = m_lvl & ~m_lvl_prev;
      for (int i = 0; i < NB; i++) begin
        if (tick) begin
          if (m_syn2[i] != m_lvl[i]) begin
            m_dcnt[i]++;
            if (m_dcnt[i] == DC) begin
              n_lvl[i]  = ~m_lvl[i];
              m_dcnt[i] = 0;
            end
          end else begin
            m_dcnt[i] = 0;
          end
        end
`ifdef BTN_AUTO_REPEAT_EN
        if (!m_lvl[i]) m_rt[i] = 0;
        else if (tick) begin
          m_rt[i]++;
          if (m_rt[i] == RD || (m_rt[i] > RD && (m_rt[i] - RD) % RR == 0)) n_press[i] = 1'b1;
        end
`endif
      end
      hi = -1;
      for (int i = 0; i < NB; i++) if (m_pend[i]) hi = i;
      sel = '0;
      if (m_q.size() != 0 && evt_ready) void'(m_q.pop_front());
      if (hi >= 0) begin
        sel[hi] = 1'b1;
        if (m_q.size() < FD) m_q.push_back(hi);
        else m_ovf = 1'b1;
      end
      m_pend     = (m_pend & ~sel) | m_press;
      m_syn2     = m_syn1;
      m_syn1     = btn_raw;
      m_lvl_prev = m_lvl;
      m_lvl      = n_lvl;
      m_press    = n_press;
      m_cyc++;
    end
  end

  int press_cnt [NB] = '{default: 0};
  int acc [$];

  always @(negedge clk) begin
    if (started) begin
      check("level", btn_level, m_lvl);
      check("press", btn_press, m_press);
      check("valid", evt_valid, m_q.size() != 0);
      check("count", evt_count, m_q.size());
      check("overflow", overflow, m_ovf);
      if (m_q.size() != 0) check("code", evt_code, m_q[0]);
      for (int i = 0; i < NB; i++) press_cnt[i] += btn_press[i];
      if (evt_valid && evt_ready) acc.push_back(evt_code);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  int  base_p, base_a;
  bit  saw, found;

  initial begin
    reset = 1'b1; btn_raw = '0; evt_ready = 1'b0;
    run(3);
    reset = 1'b0;
    check("rst_level", btn_level, 0);
    check("rst_press", btn_press, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_code", evt_code, 0);
    check("rst_count", evt_count, 0);
    check("rst_ovf", overflow, 0);

    // single press on channel 3, consumer always ready
    evt_ready = 1'b1; base_p = press_cnt[3]; base_a = acc.size(); saw = 1'b0;
    btn_raw[3] = 1'b1;
    for (int c = 0; c < 40; c++) begin step(); if (btn_level[3]) saw = 1'b1; end
    btn_raw[3] = 1'b0;
    run(30);
    check("single_level_rose", saw, 1);
    check("single_press_pulses", press_cnt[3] - base_p, 1);
    check("single_events", acc.size() - base_a, 1);
    if (acc.size() > base_a) check("single_code", acc[base_a], 3);

    // glitch shorter than DC ticks
    base_p = press_cnt[0]; base_a = acc.size(); saw = 1'b0;
    btn_raw[0] = 1'b1;
    run(6);
    btn_raw[0] = 1'b0;
    for (int c = 0; c < 30; c++) begin step(); if (btn_level[0]) saw = 1'b1; end
    check("glitch_level", saw, 0);
    check("glitch_press", press_cnt[0] - base_p, 0);
    check("glitch_events", acc.size() - base_a, 0);

    // simultaneous presses 1 and 5, consumer stalled
    evt_ready = 1'b0;
    btn_raw = 7'b010_0010;
    run(25);
    btn_raw = '0;
    run(25);
    check("simul_count", evt_count, 2);
    check("simul_head", evt_code, 5);
    base_a = acc.size();
    evt_ready = 1'b1;
    run(2);
    evt_ready = 1'b0;
    check("simul_pops", acc.size() - base_a, 2);
    if (acc.size() >= base_a + 2) begin
      check("simul_first", acc[base_a], 5);
      check("simul_second", acc[base_a + 1], 1);
    end
    check("simul_empty", evt_count, 0);

    // overflow: five sequential presses into a four-entry queue
    for (int k = 0; k < 5; k++) begin
      btn_raw = NB'(1 << k);
      run(20);
      btn_raw = '0;
      run(20);
    end
    check("ovf_count", evt_count, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_head", evt_code, 0);

    // push and pop in the same cycle on a full queue
    base_a = acc.size();
    btn_raw[6] = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 60 && !found; w++) begin step(); found = m_press[6]; end
    check("pp_press_seen", found, 1);
    step();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("pp_count", evt_count, 4);
    btn_raw[6] = 1'b0;
    run(25);
    evt_ready = 1'b1;
    run(4);
    evt_ready = 1'b0;
    check("drain_pops", acc.size() - base_a, 5);
    if (acc.size() >= base_a + 5) begin
      check("drain_0", acc[base_a], 0);
      check("drain_1", acc[base_a + 1], 1);
      check("drain_2", acc[base_a + 2], 2);
      check("drain_3", acc[base_a + 3], 3);
      check("drain_6", acc[base_a + 4], 6);
    end
    check("ovf_sticky", overflow, 1);

    // reset with three queued events
    for (int k = 2; k <= 6; k += 2) begin
      btn_raw = NB'(1 << k);
      run(20);
      btn_raw = '0;
      run(20);
    end
    check("pre_rst_count", evt_count, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_count", evt_count, 0);
    check("mid_rst_code", evt_code, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_level", btn_level, 0);
    base_a = acc.size();
    evt_ready = 1'b1;
    run(40);
    check("no_stale_events", acc.size() - base_a, 0);

`ifdef BTN_AUTO_REPEAT_EN
    base_p = press_cnt[2];
    btn_raw[2] = 1'b1;
    run(60);
    btn_raw[2] = 1'b0;
    run(20);
    check("repeat_pulses", (press_cnt[2] - base_p) >= 3, 1);
    base_p = press_cnt[2];
    run(30);
    check("repeat_stopped", press_cnt[2] - base_p, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
